// File: rtl/sram_2p_pkg.sv
// Shared types and helpers for the two-port byte-masked SRAM controller.
package sram_2p_pkg;

  // Clear sequencer states.
  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Widest word the merge helper supports; callers zero-extend into it.
  localparam int unsigned MaxDataWidth = 256;
  localparam int unsigned MaxIdxWidth  = 8;

  // Replace the byte lanes of old_word selected by mask with new_word's lanes.
  function automatic logic [MaxDataWidth-1:0] byte_merge(
    input logic [MaxDataWidth-1:0] old_word,
    input logic [MaxDataWidth-1:0] new_word,
    input logic [MaxDataWidth-1:0] mask,
    input int unsigned             byte_w
  );
    logic [MaxDataWidth-1:0] res;
    logic [MaxIdxWidth-1:0]  bit_idx;
    logic [MaxIdxWidth-1:0]  lane_idx;
    res = old_word;
    for (int unsigned i = 0; i < MaxDataWidth; i++) begin
      bit_idx  = MaxIdxWidth'(i);
      lane_idx = (byte_w == 0) ? '0 : MaxIdxWidth'(i / byte_w);
      if (byte_w != 0 && mask[lane_idx]) begin
        res[bit_idx] = new_word[bit_idx];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_2p_array.sv
// Unreset storage: two byte-masked write ports, two registered read ports.
module sram_2p_array
  import sram_2p_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 6,
  parameter int unsigned P_BYTE_WIDTH = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 a_we_i,
  input  logic [P_ADDR_WIDTH-1:0]              a_waddr_i,
  input  logic [P_DATA_WIDTH-1:0]              a_wdata_i,
  input  logic [P_DATA_WIDTH/P_BYTE_WIDTH-1:0] a_wmask_i,
  input  logic                                 b_we_i,
  input  logic [P_ADDR_WIDTH-1:0]              b_waddr_i,
  input  logic [P_DATA_WIDTH-1:0]              b_wdata_i,
  input  logic [P_DATA_WIDTH/P_BYTE_WIDTH-1:0] b_wmask_i,
  input  logic                                 a_re_i,
  input  logic [P_ADDR_WIDTH-1:0]              a_raddr_i,
  output logic [P_DATA_WIDTH-1:0]              a_rdata_o,
  input  logic                                 b_re_i,
  input  logic [P_ADDR_WIDTH-1:0]              b_raddr_i,
  output logic [P_DATA_WIDTH-1:0]              b_rdata_o
);

  localparam int unsigned NB    = P_DATA_WIDTH / P_BYTE_WIDTH;
  localparam int unsigned Depth = 2 ** P_ADDR_WIDTH;

  logic [P_DATA_WIDTH-1:0] mem_q [Depth];
  logic [P_DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

  // Lane writes; B is applied first so A owns overlapping lanes of a shared word.
  always_ff @(posedge clk_i) begin
    for (int unsigned l = 0; l < NB; l++) begin
      if (b_we_i && b_wmask_i[l]) begin
        mem_q[b_waddr_i][l*P_BYTE_WIDTH +: P_BYTE_WIDTH] <= b_wdata_i[l*P_BYTE_WIDTH +: P_BYTE_WIDTH];
      end
      if (a_we_i && a_wmask_i[l]) begin
        mem_q[a_waddr_i][l*P_BYTE_WIDTH +: P_BYTE_WIDTH] <= a_wdata_i[l*P_BYTE_WIDTH +: P_BYTE_WIDTH];
      end
    end
  end

  // Registered reads sample the pre-write word and hold between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re_i) a_rdata_q <= mem_q[a_raddr_i];
      if (b_re_i) b_rdata_q <= mem_q[b_raddr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/sram_2p_param_ctrl.sv
// Two-port byte-masked SRAM with clear sequencer, collision flag and cross-port
// write-through.
module sram_2p_param_ctrl
  import sram_2p_pkg::*;
#(
  parameter int unsigned             P_DATA_WIDTH = 32,
  parameter int unsigned             P_ADDR_WIDTH = 6,
  parameter int unsigned             P_BYTE_WIDTH = 8,
  parameter logic [P_DATA_WIDTH-1:0] P_INIT_VALUE = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 init_req_i,
  output logic                                 init_busy_o,
  input  logic                                 a_men_i,
  input  logic                                 a_wen_i,
  input  logic                                 a_ren_i,
  input  logic [P_ADDR_WIDTH-1:0]              a_addr_i,
  input  logic [P_DATA_WIDTH-1:0]              a_din_i,
  input  logic [P_DATA_WIDTH/P_BYTE_WIDTH-1:0] a_bm_i,
  output logic [P_DATA_WIDTH-1:0]              a_dout_o,
  output logic                                 a_dvalid_o,
  input  logic                                 b_men_i,
  input  logic                                 b_wen_i,
  input  logic                                 b_ren_i,
  input  logic [P_ADDR_WIDTH-1:0]              b_addr_i,
  input  logic [P_DATA_WIDTH-1:0]              b_din_i,
  input  logic [P_DATA_WIDTH/P_BYTE_WIDTH-1:0] b_bm_i,
  output logic [P_DATA_WIDTH-1:0]              b_dout_o,
  output logic                                 b_dvalid_o,
  output logic                                 coll_o
);

  localparam int unsigned           NB       = P_DATA_WIDTH / P_BYTE_WIDTH;
  localparam logic [P_ADDR_WIDTH-1:0] LastAddr = '1;
  localparam logic [P_ADDR_WIDTH-1:0] AddrOne  = P_ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [P_ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                    run;
  logic                    a_rd, a_wr, b_rd, b_wr, a_act, b_act, same_addr;
  logic                    a_wt, b_wt, coll_d;
  logic [NB-1:0]           ov_mask;
  logic [P_DATA_WIDTH-1:0] ov_data;

  logic                    arr_a_we;
  logic [P_ADDR_WIDTH-1:0] arr_a_addr;
  logic [P_DATA_WIDTH-1:0] arr_a_wdata;
  logic [NB-1:0]           arr_a_wmask;
  logic [P_DATA_WIDTH-1:0] a_rdata, b_rdata;

  logic                    a_dvalid_q, b_dvalid_q, coll_q;
  logic [NB-1:0]           a_ovm_q, b_ovm_q;
  logic [P_DATA_WIDTH-1:0] a_ovd_q, b_ovd_q;

  // Clear sequencer state and address counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer next state: sweep every address once, restart on request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        if (init_req_i) begin
          cnt_d = '0;
        end else if (cnt_q == LastAddr) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AddrOne;
        end
      end
      StRun: begin
        if (init_req_i) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // Request decode, collision detect and write-through overlay.
  always_comb begin
    run       = (state_q == StRun);
    a_rd      = run & a_men_i & a_ren_i;
    a_wr      = run & a_men_i & a_wen_i;
    b_rd      = run & b_men_i & b_ren_i;
    b_wr      = run & b_men_i & b_wen_i;
    a_act     = a_men_i & (a_wen_i | a_ren_i);
    b_act     = b_men_i & (b_wen_i | b_ren_i);
    same_addr = (a_addr_i == b_addr_i);
    coll_d    = run & a_act & b_act & same_addr & (a_wen_i | b_wen_i);
    // A reader only sees new data when the other port writes its address.
    a_wt      = a_rd & b_wr & same_addr;
    b_wt      = b_rd & a_wr & same_addr;
    ov_mask   = (a_wr ? a_bm_i : '0) | (b_wr ? b_bm_i : '0);
    ov_data   = P_DATA_WIDTH'(byte_merge(MaxDataWidth'(b_din_i), MaxDataWidth'(a_din_i),
                                         MaxDataWidth'(a_bm_i), P_BYTE_WIDTH));
  end

  // Array write port A is shared between the clear sequencer and port A.
  always_comb begin
    arr_a_we    = a_wr;
    arr_a_addr  = a_addr_i;
    arr_a_wdata = a_din_i;
    arr_a_wmask = a_bm_i;
    if (!run) begin
      arr_a_we    = 1'b1;
      arr_a_addr  = cnt_q;
      arr_a_wdata = P_INIT_VALUE;
      arr_a_wmask = '1;
    end
  end

  sram_2p_array #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_ADDR_WIDTH (P_ADDR_WIDTH),
    .P_BYTE_WIDTH (P_BYTE_WIDTH)
  ) u_array (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .a_we_i    (arr_a_we),
    .a_waddr_i (arr_a_addr),
    .a_wdata_i (arr_a_wdata),
    .a_wmask_i (arr_a_wmask),
    .b_we_i    (b_wr),
    .b_waddr_i (b_addr_i),
    .b_wdata_i (b_din_i),
    .b_wmask_i (b_bm_i),
    .a_re_i    (a_rd),
    .a_raddr_i (a_addr_i),
    .a_rdata_o (a_rdata),
    .b_re_i    (b_rd),
    .b_raddr_i (b_addr_i),
    .b_rdata_o (b_rdata)
  );

  // Output strobes and per-port overlays; overlays only change on that port's read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_dvalid_q <= 1'b0;
      b_dvalid_q <= 1'b0;
      coll_q     <= 1'b0;
      a_ovm_q    <= '0;
      b_ovm_q    <= '0;
      a_ovd_q    <= '0;
      b_ovd_q    <= '0;
    end else begin
      a_dvalid_q <= a_rd;
      b_dvalid_q <= b_rd;
      coll_q     <= coll_d;
      if (a_rd) begin
        a_ovm_q <= a_wt ? ov_mask : '0;
        a_ovd_q <= ov_data;
      end
      if (b_rd) begin
        b_ovm_q <= b_wt ? ov_mask : '0;
        b_ovd_q <= ov_data;
      end
    end
  end

  assign a_dout_o    = P_DATA_WIDTH'(byte_merge(MaxDataWidth'(a_rdata), MaxDataWidth'(a_ovd_q),
                                                MaxDataWidth'(a_ovm_q), P_BYTE_WIDTH));
  assign b_dout_o    = P_DATA_WIDTH'(byte_merge(MaxDataWidth'(b_rdata), MaxDataWidth'(b_ovd_q),
                                                MaxDataWidth'(b_ovm_q), P_BYTE_WIDTH));
  assign a_dvalid_o  = a_dvalid_q;
  assign b_dvalid_o  = b_dvalid_q;
  assign coll_o      = coll_q;
  assign init_busy_o = (state_q == StInit);

endmodule

// File: tb/tb_sram_2p_param_ctrl.sv
// Directed bench for sram_2p_param_ctrl with a word/lane-level reference model.
module tb_sram_2p_param_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          init_req, init_busy;
  logic          a_men, a_wen, a_ren, b_men, b_wen, b_ren;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din, a_dout, b_dout;
  logic [NB-1:0] a_bm, b_bm;
  logic          a_dvalid, b_dvalid, coll;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  sram_2p_param_ctrl #(
    .P_DATA_WIDTH (DW),
    .P_ADDR_WIDTH (AW),
    .P_BYTE_WIDTH (8),
    .P_INIT_VALUE ('0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .init_req_i  (init_req),
    .init_busy_o (init_busy),
    .a_men_i     (a_men),
    .a_wen_i     (a_wen),
    .a_ren_i     (a_ren),
    .a_addr_i    (a_addr),
    .a_din_i     (a_din),
    .a_bm_i      (a_bm),
    .a_dout_o    (a_dout),
    .a_dvalid_o  (a_dvalid),
    .b_men_i     (b_men),
    .b_wen_i     (b_wen),
    .b_ren_i     (b_ren),
    .b_addr_i    (b_addr),
    .b_din_i     (b_din),
    .b_bm_i      (b_bm),
    .b_dout_o    (b_dout),
    .b_dvalid_o  (b_dvalid),
    .coll_o      (coll)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [64];
  int            m_cnt;
  bit            m_busy;
  logic [DW-1:0] m_adout, m_bdout;
  bit            m_adv, m_bdv, m_coll;

  function automatic logic [DW-1:0] put_lanes(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                              input logic [NB-1:0] m);
    logic [DW-1:0] r;
    r = o;
    for (int l = 0; l < NB; l++) if (m[l]) r[8*l +: 8] = n[8*l +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [DW-1:0] old_a, old_b;
    bit aw, ar, bw, br;
    if (!rst_n) begin
      m_busy = 1; m_cnt = 0; m_adout = 0; m_bdout = 0; m_adv = 0; m_bdv = 0; m_coll = 0;
    end else begin
      m_adv = 0; m_bdv = 0; m_coll = 0;
      if (m_busy) begin
        m_mem[m_cnt] = '0;
        if (init_req) m_cnt = 0;
        else if (m_cnt == 63) begin m_busy = 0; m_cnt = 0; end
        else m_cnt++;
      end else begin
        aw = a_men && a_wen; ar = a_men && a_ren;
        bw = b_men && b_wen; br = b_men && b_ren;
        old_a = m_mem[a_addr];
        old_b = m_mem[b_addr];
        if (bw) m_mem[b_addr] = put_lanes(m_mem[b_addr], b_din, b_bm);
        if (aw) m_mem[a_addr] = put_lanes(m_mem[a_addr], a_din, a_bm);
        if (ar) begin
          m_adv = 1;
          m_adout = (bw && b_addr == a_addr) ? m_mem[a_addr] : old_a;
        end
        if (br) begin
          m_bdv = 1;
          m_bdout = (aw && a_addr == b_addr) ? m_mem[b_addr] : old_b;
        end
        m_coll = (a_men && (a_wen || a_ren)) && (b_men && (b_wen || b_ren)) &&
                 (a_addr == b_addr) && (aw || bw);
        if (init_req) begin m_busy = 1; m_cnt = 0; end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_dout", a_dout, m_adout);
      chk("b_dout", b_dout, m_bdout);
      chk("a_dvalid", 32'(a_dvalid), 32'(m_adv));
      chk("b_dvalid", 32'(b_dvalid), 32'(m_bdv));
      chk("coll", 32'(coll), 32'(m_coll));
      chk("init_busy", 32'(init_busy), 32'(m_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    a_men = 0; a_wen = 0; a_ren = 0; a_addr = '0; a_din = '0; a_bm = '0;
    b_men = 0; b_wen = 0; b_ren = 0; b_addr = '0; b_din = '0; b_bm = '0;
    init_req = 0;
  endtask

  // Applies the currently driven request on one edge, then returns to idle.
  task automatic step();
    @(posedge clk); #2;
    idle();
  endtask

  task automatic set_a(input bit w, input bit r, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic [NB-1:0] m);
    a_men = 1; a_wen = w; a_ren = r; a_addr = ad; a_din = d; a_bm = m;
  endtask

  task automatic set_b(input bit w, input bit r, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic [NB-1:0] m);
    b_men = 1; b_wen = w; b_ren = r; b_addr = ad; b_din = d; b_bm = m;
  endtask

  // Counts sampled cycles with init_busy high, bounded.
  task automatic count_busy(input string name);
    int n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!init_busy) break;
      n++;
      @(posedge clk); #2;
    end
    chk(name, 32'(n), 32'd64);
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 64; i++) begin
      set_a(0, 1, AW'(i), '0, '0);
      set_b(0, 1, AW'(63 - i), '0, '0);
      step();
      chk({name, "_a_dout"}, a_dout, 32'h0);
      chk({name, "_a_dvalid"}, 32'(a_dvalid), 32'd1);
      chk({name, "_b_dout"}, b_dout, 32'h0);
    end
  endtask

  initial begin
    idle();
    #1 rst_n = 0;
    cmp_en = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_a_dout", a_dout, 32'h0);
    chk("rst_coll", 32'(coll), 32'd0);
    rst_n = 1;
    // Reads issued during the clear must be ignored.
    set_a(0, 1, 6'd3, '0, '0);
    count_busy("busy_after_reset");
    idle();
    read_all_zero("clear0");

    // Byte-masked overwrite.
    set_a(1, 0, 6'd5, 32'hDEADBEEF, 4'b1111); step();
    set_a(1, 0, 6'd5, 32'h11223344, 4'b0101); step();
    set_b(0, 1, 6'd5, '0, '0); step();
    chk("bm_merge_b_dout", b_dout, 32'hDE22BE44);
    chk("bm_merge_b_dvalid", 32'(b_dvalid), 32'd1);
    step();
    chk("dvalid_one_cycle", 32'(b_dvalid), 32'd0);
    chk("dout_hold", b_dout, 32'hDE22BE44);

    // Disabled / no-op requests change nothing.
    a_men = 0; a_wen = 1; a_addr = 6'd5; a_din = 32'h0; a_bm = 4'hF; step();
    set_a(0, 0, 6'd5, 32'h0, 4'hF); step();
    chk("noop_dvalid", 32'(a_dvalid), 32'd0);
    set_a(0, 1, 6'd5, '0, '0); step();
    chk("noop_mem", a_dout, 32'hDE22BE44);

    // Dual write to one address.
    set_a(1, 0, 6'd9, 32'hAAAAAAAA, 4'b0011);
    set_b(1, 0, 6'd9, 32'h55555555, 4'b0110);
    step();
    chk("dual_wr_coll", 32'(coll), 32'd1);
    step();
    chk("dual_wr_coll_pulse", 32'(coll), 32'd0);
    set_a(0, 1, 6'd9, '0, '0); step();
    chk("dual_wr_data", a_dout, 32'h0055AAAA);

    // Cross-port write-through and read-before-write.
    set_a(1, 0, 6'd12, 32'hCAFEF00D, 4'hF);
    set_b(0, 1, 6'd12, '0, '0);
    step();
    chk("wt_b_dout", b_dout, 32'hCAFEF00D);
    chk("wt_coll", 32'(coll), 32'd1);
    set_a(1, 1, 6'd12, 32'h00000001, 4'hF); step();
    chk("rbw_a_dout", a_dout, 32'hCAFEF00D);
    chk("rbw_coll", 32'(coll), 32'd0);
    set_a(0, 1, 6'd12, '0, '0);
    set_b(0, 1, 6'd12, '0, '0);
    step();
    chk("rbw_new_word", b_dout, 32'h00000001);
    chk("two_reads_no_coll", 32'(coll), 32'd0);

    // Both writing with B also reading: B sees the merged word.
    set_a(1, 0, 6'd20, 32'h12345678, 4'b1001);
    set_b(1, 1, 6'd20, 32'h9ABCDEF0, 4'b1111);
    step();
    chk("wt_merge_b_dout", b_dout, 32'h12BCDE78);

    // Fill, then clear request interrupted by reset.
    for (int i = 0; i < 32; i++) begin
      set_a(1, 0, AW'(i), 32'hA5000000 | 32'(i), 4'hF);
      set_b(1, 0, AW'(i + 32), 32'h5A000000 | 32'(i + 32), 4'hF);
      step();
    end
    set_a(0, 1, 6'd7, '0, '0);
    set_b(0, 1, 6'd40, '0, '0);
    step();
    chk("fill_a", a_dout, 32'hA5000007);
    chk("fill_b", b_dout, 32'h5A000028);
    init_req = 1; step();
    chk("init_req_busy", 32'(init_busy), 32'd1);
    repeat (30) begin @(posedge clk); #2; end
    rst_n = 0;
    #3;
    chk("midinit_rst_busy", 32'(init_busy), 32'd1);
    chk("midinit_rst_a_dout", a_dout, 32'h0);
    chk("midinit_rst_b_dout", b_dout, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1;
    count_busy("busy_after_midinit_reset");
    read_all_zero("clear1");

    repeat (2) @(posedge clk);
    #2;
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
